// File: rtl/ym_serial_pkg.sv
// Shared types and defaults for the YMF262 serial DAC transmitter.
package ym_serial_pkg;

   localparam int unsigned YM_SAMPLE_W      = 16;
   localparam int unsigned YM_DCLK_DIV_DEF  = 8;
   localparam int unsigned YM_SLOT_BITS_DEF = 18;

   typedef struct packed {
      logic [YM_SAMPLE_W-1:0] left;
      logic [YM_SAMPLE_W-1:0] right;
   } ym_stereo_t;

   typedef enum logic [1:0] {
      SlotLeft,
      SlotGapL,
      SlotRight,
      SlotGapR
   } ym_slot_e;

   // Classify a bit index b of the frame into its slot region.
   function automatic ym_slot_e ym_slot(input int unsigned b, input int unsigned slot_bits);
      ym_slot_e s;
      if (b < YM_SAMPLE_W) begin
         s = SlotLeft;
      end else if (b < slot_bits) begin
         s = SlotGapL;
      end else if (b < slot_bits + YM_SAMPLE_W) begin
         s = SlotRight;
      end else begin
         s = SlotGapR;
      end
      return s;
   endfunction

endpackage

// File: rtl/ym_serial_timing.sv
// Bit clock divider and frame bit counter for the YMF262 serial stream.
// bit_adv marks the cycle ym_dclk falls; frame_start marks the wrap to b=0.
module ym_serial_timing
   import ym_serial_pkg::*;
#(
   parameter int unsigned DCLK_DIV  = YM_DCLK_DIV_DEF,
   parameter int unsigned SLOT_BITS = YM_SLOT_BITS_DEF,
   parameter int unsigned BIT_W     = $clog2(2 * SLOT_BITS)
) (
   input  logic             clk28,
   input  logic             rst,
   output logic             ym_dclk,
   output logic [BIT_W-1:0] b,
   output logic             bit_adv,
   output logic             frame_start
);

   localparam int unsigned      CNT_W    = $clog2(DCLK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DCLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [BIT_W-1:0] b_q, b_d;
   logic             dclk_q, dclk_d;
   logic             tc;

   always_comb begin
      tc          = (cnt_q == CNT_LAST);
      cnt_d       = tc ? '0 : cnt_q + CNT_W'(1);
      dclk_d      = tc ? ~dclk_q : dclk_q;
      bit_adv     = tc & dclk_q;
      frame_start = bit_adv & (b_q == BIT_LAST);
      b_d         = b_q;
      if (bit_adv) begin
         b_d = frame_start ? '0 : b_q + BIT_W'(1);
      end
   end

   // b resets to the last index so the first falling edge opens a frame.
   always_ff @(posedge clk28) begin
      if (rst) begin
         cnt_q  <= '0;
         dclk_q <= 1'b0;
         b_q    <= BIT_LAST;
      end else begin
         cnt_q  <= cnt_d;
         dclk_q <= dclk_d;
         b_q    <= b_d;
      end
   end

   assign ym_dclk = dclk_q;
   assign b       = b_q;

endmodule

// File: rtl/ym_serial_tx.sv
// YMF262 serial DAC transmitter: single-entry holding register, LSB-first shifters.
// Define YM_SERIAL_TX_HOLD_EN to repeat the previous pair on underrun (else send zeros).
module ym_serial_tx
   import ym_serial_pkg::*;
#(
   parameter int unsigned DCLK_DIV  = YM_DCLK_DIV_DEF,
   parameter int unsigned SLOT_BITS = YM_SLOT_BITS_DEF
) (
   input  logic                   clk28,
   input  logic                   rst,
   input  logic [YM_SAMPLE_W-1:0] s_left,
   input  logic [YM_SAMPLE_W-1:0] s_right,
   input  logic                   s_valid,
   output logic                   s_ready,
   output logic                   ym_dclk,
   output logic [2:1]             ym_smp,
   output logic                   ym_data,
   output logic                   underrun
);

   localparam int unsigned BIT_W = $clog2(2 * SLOT_BITS);

   logic [BIT_W-1:0] b;
   logic             bit_adv;
   logic             frame_start;
   logic             hs;
   ym_slot_e         slot;
   ym_stereo_t       hold_q, hold_d;
   ym_stereo_t       sh_q, sh_d;
   ym_stereo_t       fill;
   logic             full_q, full_d;
   logic             underrun_q, underrun_d;

   ym_serial_timing #(
      .DCLK_DIV  (DCLK_DIV),
      .SLOT_BITS (SLOT_BITS),
      .BIT_W     (BIT_W)
   ) u_timing (
      .clk28       (clk28),
      .rst         (rst),
      .ym_dclk     (ym_dclk),
      .b           (b),
      .bit_adv     (bit_adv),
      .frame_start (frame_start)
   );

`ifdef YM_SERIAL_TX_HOLD_EN
   ym_stereo_t last_q;

   always_ff @(posedge clk28) begin
      if (rst) begin
         last_q <= '0;
      end else if (frame_start) begin
         last_q <= sh_d;
      end
   end

   assign fill = last_q;
`else
   assign fill = '0;
`endif

   always_comb begin
      hs         = s_valid & ~full_q;
      slot       = ym_slot(32'(b), SLOT_BITS);
      full_d     = full_q;
      hold_d     = hold_q;
      sh_d       = sh_q;
      underrun_d = 1'b0;
      if (frame_start) begin
         full_d = 1'b0;
         if (full_q) begin
            sh_d = hold_q;
         end else begin
            sh_d       = fill;
            underrun_d = 1'b1;
         end
      end else if (bit_adv) begin
         if (slot == SlotLeft) begin
            sh_d.left = sh_q.left >> 1;
         end
         if (slot == SlotRight) begin
            sh_d.right = sh_q.right >> 1;
         end
      end
      // A handshake coinciding with a load refills the register just emptied.
      if (hs) begin
         hold_d = {s_left, s_right};
         full_d = 1'b1;
      end
   end

   always_ff @(posedge clk28) begin
      if (rst) begin
         hold_q     <= '0;
         sh_q       <= '0;
         full_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         hold_q     <= hold_d;
         sh_q       <= sh_d;
         full_q     <= full_d;
         underrun_q <= underrun_d;
      end
   end

   always_comb begin
      ym_smp  = 2'b00;
      ym_data = 1'b0;
      unique case (slot)
         SlotLeft: begin
            ym_smp[1] = 1'b1;
            ym_data   = sh_q.left[0];
         end
         SlotRight: begin
            ym_smp[2] = 1'b1;
            ym_data   = sh_q.right[0];
         end
         SlotGapL, SlotGapR: begin
            ym_smp  = 2'b00;
            ym_data = 1'b0;
         end
         default: begin
            ym_smp  = 2'b00;
            ym_data = 1'b0;
         end
      endcase
   end

   assign s_ready  = ~full_q;
   assign underrun = underrun_q;

endmodule

// File: tb/tb_ym_serial_tx.sv
// Scoreboard bench for ym_serial_tx: a receiver model samples on ym_dclk rise and
// compares each recovered frame against the expected-pair queue filled by the stimulus.
module tb_ym_serial_tx;
   import ym_serial_pkg::*;

   localparam int unsigned DIV   = 8;
   localparam int unsigned SB    = 18;
   localparam int unsigned FRAME = 2 * DIV * 2 * SB;

`ifdef YM_SERIAL_TX_HOLD_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif

   logic        clk28 = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] s_left = '0;
   logic [15:0] s_right = '0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic        ym_dclk;
   logic [2:1]  ym_smp;
   logic        ym_data;
   logic        underrun;

   always #5 clk28 = ~clk28;

   ym_serial_tx #(
      .DCLK_DIV  (DIV),
      .SLOT_BITS (SB)
   ) dut (
      .clk28    (clk28),
      .rst      (rst),
      .s_left   (s_left),
      .s_right  (s_right),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .ym_dclk  (ym_dclk),
      .ym_smp   (ym_smp),
      .ym_data  (ym_data),
      .underrun (underrun)
   );

   int          n_tests = 0;
   int          n_fail = 0;
   int unsigned cyc = 0;

   always @(posedge clk28) cyc <= cyc + 1;

   task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Scoreboard and receiver model state.
   logic [31:0] exp_q[$];
   int          frames_done, ucount, u_wide, u_misalign;
   int          lcnt, rcnt, gmid, gtail;
   logic        gap_bad;
   logic [15:0] lw, rw;
   logic        prev_dclk, prev_smp1, prev_und;
   int unsigned t_rise, dclk_period, dclk_high, t_smp1, smp1_period;

   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk28);
         if (rst) begin
            frames_done = 0; ucount = 0; u_wide = 0; u_misalign = 0;
            lcnt = 0; rcnt = 0; gmid = 0; gtail = 0; gap_bad = 1'b0;
            lw = '0; rw = '0;
            prev_dclk = 1'b0; prev_smp1 = 1'b0; prev_und = 1'b0;
            t_rise = 0; dclk_period = 0; dclk_high = 0; t_smp1 = 0; smp1_period = 0;
         end else begin
            if (underrun) begin
               ucount++;
               if (prev_und) u_wide++;
               if (!(ym_smp[1] && !prev_smp1)) u_misalign++;
            end
            if (ym_smp[1] && !prev_smp1) begin
               if (t_smp1 != 0) smp1_period = cyc - t_smp1;
               t_smp1 = cyc;
            end
            if (!ym_dclk && prev_dclk) dclk_high = cyc - t_rise;
            if (ym_dclk && !prev_dclk) begin
               if (t_rise != 0) dclk_period = cyc - t_rise;
               t_rise = cyc;
               if (ym_smp == 2'b01) begin
                  if (rcnt != 0) begin
                     check("frame_tail", {32'(rcnt), 32'(gtail), 32'(gap_bad)},
                           {32'd16, 32'(SB - 16), 32'd0});
                     lcnt = 0; rcnt = 0; gmid = 0; gtail = 0; gap_bad = 1'b0;
                  end
                  if (lcnt < 16) lw[lcnt] = ym_data;
                  lcnt++;
               end else if (ym_smp == 2'b10) begin
                  if (rcnt < 16) rw[rcnt] = ym_data;
                  rcnt++;
                  if (rcnt == 16) begin
                     frames_done++;
                     check("frame_shape", {32'(lcnt), 32'(gmid), 32'(gap_bad)},
                           {32'd16, 32'(SB - 16), 32'd0});
                     if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_frame: got %h expected no frame", {lw, rw});
                     end else begin
                        e = exp_q.pop_front();
                        check("frame_data", {lw, rw}, e);
                     end
                  end
               end else if (ym_smp == 2'b11) begin
                  gap_bad = 1'b1;
               end else begin
                  if (ym_data) gap_bad = 1'b1;
                  if (lcnt != 0) begin
                     if (rcnt == 0) gmid++;
                     else gtail++;
                  end
               end
            end
            prev_dclk = ym_dclk;
            prev_smp1 = ym_smp[1];
            prev_und  = underrun;
         end
      end
   end

   task automatic do_reset(input string name);
      @(negedge clk28);
      rst = 1'b1;
      @(negedge clk28);
      check(name, {ym_dclk, ym_smp, ym_data, underrun, s_ready}, 6'b000001);
      repeat (2) @(negedge clk28);
      exp_q.delete();
      rst = 1'b0;
   endtask

   task automatic after_release(output int rdy1, output int t_dclk, output int t_frame);
      rdy1 = 0; t_dclk = 0; t_frame = 0;
      for (int k = 1; k <= 24; k++) begin
         @(negedge clk28);
         if (k == 1) begin
            rdy1    = int'(s_ready);
            s_valid = 1'b0;
         end
         if (ym_dclk && t_dclk == 0) t_dclk = k;
         if (ym_smp[1] && t_frame == 0) t_frame = k;
      end
   endtask

   task automatic wait_frames(input int n, input int budget, input string name);
      int k;
      k = 0;
      while (frames_done < n && k < budget) begin
         @(negedge clk28);
         k++;
      end
      check(name, 32'(frames_done), 32'(n));
   endtask

   initial begin
      int          rdy1, td, tf, k, bad_iv, bad_single;
      int unsigned t_prev;
      logic [31:0] pr;

      // Single pair, then an underrun frame; also reset-release timing and periods.
      s_left = 16'h8001; s_right = 16'h0003; s_valid = 1'b1;
      do_reset("a_reset_state");
      exp_q.push_back(32'h8001_0003);
      exp_q.push_back(HOLD ? 32'h8001_0003 : 32'h0);
      after_release(rdy1, td, tf);
      check("a_ready_after_accept", 32'(rdy1), 32'd0);
      check("a_first_dclk_rise", 32'(td), 32'(DIV));
      check("a_first_frame_start", 32'(tf), 32'(2 * DIV));
      wait_frames(2, 3 * FRAME, "a_frames");
      check("a_queue_drained", 32'(exp_q.size()), 32'd0);
      check("a_dclk_period", 32'(dclk_period), 32'(2 * DIV));
      check("a_dclk_high", 32'(dclk_high), 32'(DIV));
      check("a_left_strobe_period", 32'(smp1_period), 32'(FRAME));
      check("a_underrun_count", 32'(ucount), 32'd1);

      // 64 back-to-back pairs with s_valid held high.
      s_valid = 1'b0;
      do_reset("b_reset_state");
      bad_iv = 0; bad_single = 0; t_prev = 0;
      for (int i = 0; i < 64; i++) begin
         pr = $urandom();
         s_left = pr[31:16]; s_right = pr[15:0]; s_valid = 1'b1;
         k = 0;
         while (!s_ready && k < 2 * FRAME) begin
            @(negedge clk28);
            k++;
         end
         if (!s_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL b_accept_timeout: got no s_ready for pair %0d expected within %0d",
                     i, 2 * FRAME);
            break;
         end
         exp_q.push_back(pr);
         if (i >= 2 && cyc - t_prev != FRAME) bad_iv++;
         t_prev = cyc;
         @(negedge clk28);
         if (s_ready) bad_single++;
      end
      s_valid = 1'b0;
      check("b_accept_interval", 32'(bad_iv), 32'd0);
      check("b_ready_single_cycle", 32'(bad_single), 32'd0);
      wait_frames(64, 3 * FRAME, "b_frames");
      check("b_queue_drained", 32'(exp_q.size()), 32'd0);
      check("b_no_underrun", 32'(ucount), 32'd0);

      // Underrun after one pair: repeat or zeros depending on the build.
      s_left = 16'h1234; s_right = 16'h5678; s_valid = 1'b1;
      do_reset("c_reset_state");
      exp_q.push_back(32'h1234_5678);
      exp_q.push_back(HOLD ? 32'h1234_5678 : 32'h0);
      after_release(rdy1, td, tf);
      check("c_ready_after_accept", 32'(rdy1), 32'd0);
      wait_frames(2, 3 * FRAME, "c_frames");
      check("c_underrun_count", 32'(ucount), 32'd1);
      check("c_underrun_width", 32'(u_wide), 32'd0);
      check("c_underrun_align", 32'(u_misalign), 32'd0);

      // Reset at b=5 of the left slot with the holding register full.
      s_left = 16'hA5C3; s_right = 16'h3C5A; s_valid = 1'b1;
      do_reset("d_reset_state");
      exp_q.push_back(32'hA5C3_3C5A);
      after_release(rdy1, td, tf);
      s_left = 16'hFFFF; s_right = 16'h0001; s_valid = 1'b1;
      @(negedge clk28);
      s_valid = 1'b0;
      check("d_holding_full", 32'(s_ready), 32'd0);
      k = 0;
      while (lcnt < 5 && k < 20 * DIV) begin
         @(negedge clk28);
         k++;
      end
      while (ym_dclk && k < 40 * DIV) begin
         @(negedge clk28);
         k++;
      end
      check("d_left_strobe_at_b5", {30'd0, ym_smp}, 32'b01);
      do_reset("d_mid_frame_reset");
      after_release(rdy1, td, tf);
      check("d_first_dclk_rise", 32'(td), 32'(DIV));
      check("d_first_frame_start", 32'(tf), 32'(2 * DIV));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #(1_000_000);
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1);
   end

endmodule
